ultrasonic_echo_emulator: RTL and testbench

- Emulates the sensor end of the HC-SR04-style TRIG/ECHO link. It is the responder to the ultrasonic trigger/echo controller.
- Accepts a TRIG pulse, waits a fixed response delay, then drives ECHO high for a width equal to the round-trip time of a programmed distance.
- Used in simulation and hardware-in-the-loop to exercise the distance path without a physical sensor.

---
 rtl/ultrasonic_echo_emulator.sv | 172 +++++++++++++++++
 tb/tb_ultrasonic_echo_emulator.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_echo_emulator.sv
// Sensor-side HC-SR04 emulator: answers a valid TRIG with an ECHO pulse whose
// width is the round-trip time of the programmed distance (or the no-object timeout).
module ultrasonic_echo_emulator #(
   parameter int unsigned CLOCK_FREQ     = 50_000_000,
   parameter int unsigned SOUND_SPEED    = 34300,
   parameter int unsigned TRIG_MIN       = 500,
   parameter int unsigned RESP_DELAY     = 10_000,
   parameter int unsigned MAX_DIST_CM    = 400,
   parameter int unsigned TIMEOUT_CYCLES = 1_900_000,
   parameter int unsigned HOLDOFF        = 500_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trig,
   input  logic [15:0] distancia_cm,
   input  logic        obj_present,
   output logic        echo,
   output logic        busy,
   output logic        short_trig,
   output logic [15:0] meas_count
);

   localparam logic [47:0] DEN       = 48'(SOUND_SPEED);
   localparam logic [47:0] TWO_F     = 48'(CLOCK_FREQ) * 48'd2;
   localparam logic [15:0] MAXD      = 16'(MAX_DIST_CM);
   localparam logic [31:0] TMIN      = 32'(TRIG_MIN);
   localparam logic [31:0] DLY_LAST  = 32'(RESP_DELAY - 2);
   localparam logic [31:0] TMO       = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF);

   typedef enum logic [2:0] {
      IDLE,
      TRIG_HI,
      DELAY,
      ECHO,
      HOLD
   } state_t;

   state_t      state;
   logic        trig_meta;
   logic        trig_s;
   logic [1:0]  sync_vld;
   logic        armed;
   logic [31:0] cnt;
   logic [31:0] width;
   logic        use_tmo;
   logic [47:0] div_num;
   logic [47:0] div_rem;
   logic [31:0] div_quo;
   logic [5:0]  div_left;

   logic [15:0] d_clamp;
   logic [47:0] num_init;
   logic [48:0] rem_shift;
   logic        rem_ge;

   always_comb begin
      d_clamp   = (distancia_cm > MAXD) ? MAXD : distancia_cm;
      // Adding DEN-1 before the truncating divide yields the ceiling.
      num_init  = 48'(d_clamp) * TWO_F + (DEN - 48'd1);
      rem_shift = {div_rem, div_num[47]};
      rem_ge    = (rem_shift >= {1'b0, DEN});
   end

   // sync_vld marks when the cleared synchronizer output reflects the real pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trig_meta <= 1'b0;
         trig_s    <= 1'b0;
         sync_vld  <= '0;
      end else begin
         trig_meta <= trig;
         trig_s    <= trig_meta;
         sync_vld  <= {sync_vld[0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         echo       <= 1'b0;
         busy       <= 1'b0;
         short_trig <= 1'b0;
         meas_count <= '0;
         armed      <= 1'b0;
         cnt        <= '0;
         width      <= '0;
         use_tmo    <= 1'b0;
         div_num    <= '0;
         div_rem    <= '0;
         div_quo    <= '0;
         div_left   <= '0;
      end else begin
         short_trig <= 1'b0;

         if (div_left != 6'd0) begin
            div_num  <= div_num << 1;
            div_rem  <= rem_ge ? 48'(rem_shift - {1'b0, DEN}) : rem_shift[47:0];
            div_quo  <= {div_quo[30:0], rem_ge};
            div_left <= div_left - 6'd1;
         end

         case (state)
            IDLE: begin
               // A line already high on entry must drop before it can arm.
               if (trig_s) begin
                  if (armed) begin
                     armed <= 1'b0;
                     cnt   <= 32'd1;
                     state <= TRIG_HI;
                  end
               end else if (sync_vld[1]) begin
                  armed <= 1'b1;
               end
            end

            TRIG_HI: begin
               if (trig_s) begin
                  if (cnt < TMIN) cnt <= cnt + 32'd1;
               end else if (cnt >= TMIN) begin
                  busy     <= 1'b1;
                  cnt      <= '0;
                  use_tmo  <= !obj_present || (d_clamp == 16'd0);
                  div_num  <= num_init;
                  div_rem  <= '0;
                  div_quo  <= '0;
                  div_left <= 6'd48;
                  state    <= DELAY;
               end else begin
                  short_trig <= 1'b1;
                  state      <= IDLE;
               end
            end

            DELAY: begin
               if (cnt == DLY_LAST) begin
                  echo  <= 1'b1;
                  cnt   <= 32'd1;
                  width <= use_tmo ? TMO : div_quo;
                  state <= ECHO;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            ECHO: begin
               if (cnt == width) begin
                  echo       <= 1'b0;
                  meas_count <= meas_count + 16'd1;
                  cnt        <= 32'd1;
                  state      <= HOLD;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator using scaled-down timing parameters.
module tb_ultrasonic_echo_emulator;

   localparam int RESP = 60;
   localparam int HOLD = 100;
   localparam int TMIN = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trig = 1'b0;
   logic [15:0] distancia_cm = 16'd100;
   logic        obj_present = 1'b1;
   logic        echo;
   logic        busy;
   logic        short_trig;
   logic [15:0] meas_count;

   int checks = 0;
   int failures = 0;
   int exp_meas = 0;

   ultrasonic_echo_emulator #(
      .CLOCK_FREQ    (50_000),
      .SOUND_SPEED   (34300),
      .TRIG_MIN      (TMIN),
      .RESP_DELAY    (RESP),
      .MAX_DIST_CM   (400),
      .TIMEOUT_CYCLES(700),
      .HOLDOFF       (HOLD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .trig        (trig),
      .distancia_cm(distancia_cm),
      .obj_present (obj_present),
      .echo        (echo),
      .busy        (busy),
      .short_trig  (short_trig),
      .meas_count  (meas_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic pulse_trig(input int hi);
      @(negedge clk);
      trig = 1'b1;
      repeat (hi) @(negedge clk);
      trig = 1'b0;
   endtask

   // dly: posedges from trig drop to echo visible; wid: echo high cycles; hold: busy after echo
   task automatic run_measure(input int hi, input logic [15:0] d_after, input logic obj_after,
                              output int dly, output int wid, output int hold);
      dly = -1; wid = -1; hold = -1;
      pulse_trig(hi);
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (k == 4) begin
            distancia_cm = d_after;
            obj_present  = obj_after;
         end
         if (echo) begin
            dly = k;
            break;
         end
      end
      if (dly < 0) return;
      wid = 0;
      for (int k = 0; k < 20000; k++) begin
         if (!echo) break;
         wid++;
         @(negedge clk);
      end
      hold = 0;
      for (int k = 0; k < 5000; k++) begin
         if (!busy) break;
         hold++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int seen;
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         trig = ~trig;
      end
      checks++;
      if (echo !== 1'b0 || busy !== 1'b0 || short_trig !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: echo=%b busy=%b short=%b required 0/0/0", echo, busy, short_trig);
      end
      checks++;
      if (meas_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_count: got %0d required 0", meas_count);
      end
      trig = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (echo || busy || short_trig) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL reset_release_idle: active cycles=%0d required 0", seen);
      end
      // trig held high across release must not count as a rising edge
      @(negedge clk);
      rst = 1'b0;
      trig = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy || short_trig) seen++;
      end
      trig = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL reset_trig_held: active cycles=%0d required 0", seen);
      end
   endtask

   task automatic test_basic;
      int dly, wid, hold;
      distancia_cm = 16'd100; obj_present = 1'b1;
      run_measure(30, 16'd5, 1'b0, dly, wid, hold);
      exp_meas++;
      checks++;
      if (dly !== RESP + 2) begin
         failures++;
         $display("FAIL basic_delay: got %0d required %0d", dly, RESP + 2);
      end
      checks++;
      if (wid !== 292) begin
         failures++;
         $display("FAIL basic_width: got %0d required 292", wid);
      end
      checks++;
      if (hold !== HOLD) begin
         failures++;
         $display("FAIL basic_holdoff: got %0d required %0d", hold, HOLD);
      end
      checks++;
      if (int'(meas_count) !== exp_meas) begin
         failures++;
         $display("FAIL basic_count: got %0d required %0d", meas_count, exp_meas);
      end
      checks++;
      if ((wid * 34300) / 100000 !== 100) begin
         failures++;
         $display("FAIL basic_readback: got %0d required 100", (wid * 34300) / 100000);
      end
   endtask

   task automatic test_short_trig;
      int n_short, first, n_busy, n_echo;
      n_short = 0; first = -1; n_busy = 0; n_echo = 0;
      pulse_trig(TMIN - 1);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (short_trig) begin
            n_short++;
            if (first < 0) first = k;
         end
         if (busy) n_busy++;
         if (echo) n_echo++;
      end
      checks++;
      if (n_short !== 1 || first !== 3) begin
         failures++;
         $display("FAIL short_strobe: pulses=%0d at=%0d required 1 at 3", n_short, first);
      end
      checks++;
      if (n_busy !== 0 || n_echo !== 0) begin
         failures++;
         $display("FAIL short_no_echo: busy=%0d echo=%0d required 0/0", n_busy, n_echo);
      end
   endtask

   task automatic test_trig_min;
      int dly, wid, hold;
      distancia_cm = 16'd100; obj_present = 1'b1;
      run_measure(TMIN, 16'd100, 1'b1, dly, wid, hold);
      exp_meas++;
      checks++;
      if (dly !== RESP + 2 || wid !== 292) begin
         failures++;
         $display("FAIL trig_min_accept: delay=%0d width=%0d required %0d/292", dly, wid, RESP + 2);
      end
   endtask

   task automatic test_widths;
      logic [15:0] dv [5] = '{16'd100, 16'd0, 16'd1000, 16'd343, 16'd1};
      logic        ov [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int          wv [5] = '{700, 700, 1167, 1000, 3};
      int dly, wid, hold;
      for (int i = 0; i < 5; i++) begin
         distancia_cm = dv[i]; obj_present = ov[i];
         run_measure(25, dv[i], ov[i], dly, wid, hold);
         exp_meas++;
         checks++;
         if (wid !== wv[i]) begin
            failures++;
            $display("FAIL width_case%0d: d=%0d obj=%b got %0d required %0d", i, dv[i], ov[i], wid, wv[i]);
         end
      end
      checks++;
      if (int'(meas_count) !== exp_meas) begin
         failures++;
         $display("FAIL widths_count: got %0d required %0d", meas_count, exp_meas);
      end
   endtask

   task automatic test_back_to_back;
      int n_short, n_rise, wcount, dly, wid, hold;
      logic prev;
      n_short = 0; n_rise = 0; wcount = 0;
      distancia_cm = 16'd100; obj_present = 1'b1;
      pulse_trig(30);
      while (!echo && wcount < 400) begin
         @(negedge clk);
         wcount++;
         if (short_trig) n_short++;
      end
      // retrigger during echo, then during holdoff
      pulse_trig(30);
      wcount = 0;
      while (echo && wcount < 2000) begin
         @(negedge clk);
         wcount++;
      end
      pulse_trig(30);
      prev = echo;
      wcount = 0;
      while (busy && wcount < 2000) begin
         @(negedge clk);
         wcount++;
         if (short_trig) n_short++;
         if (echo && !prev) n_rise++;
         prev = echo;
      end
      exp_meas++;
      checks++;
      if (busy !== 1'b0 || n_short !== 0 || n_rise !== 0) begin
         failures++;
         $display("FAIL b2b_ignored: busy=%b shorts=%0d extra_echo=%0d required 0/0/0", busy, n_short, n_rise);
      end
      checks++;
      if (int'(meas_count) !== exp_meas) begin
         failures++;
         $display("FAIL b2b_count1: got %0d required %0d", meas_count, exp_meas);
      end
      run_measure(30, 16'd100, 1'b1, dly, wid, hold);
      exp_meas++;
      checks++;
      if (dly !== RESP + 2 || wid !== 292 || int'(meas_count) !== exp_meas) begin
         failures++;
         $display("FAIL b2b_accept: delay=%0d width=%0d count=%0d required %0d/292/%0d",
                  dly, wid, meas_count, RESP + 2, exp_meas);
      end
   endtask

   task automatic test_reset_mid_echo;
      int wcount, dly, wid, hold;
      distancia_cm = 16'd100; obj_present = 1'b1;
      pulse_trig(30);
      wcount = 0;
      while (!echo && wcount < 400) begin
         @(negedge clk);
         wcount++;
      end
      repeat (146) @(negedge clk);
      checks++;
      if (echo !== 1'b1) begin
         failures++;
         $display("FAIL mid_echo_high: got %b required 1", echo);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (echo !== 1'b0 || busy !== 1'b0 || meas_count !== 16'd0) begin
         failures++;
         $display("FAIL mid_echo_reset: echo=%b busy=%b count=%0d required 0/0/0", echo, busy, meas_count);
      end
      @(negedge clk);
      rst = 1'b1;
      exp_meas = 0;
      repeat (5) @(negedge clk);
      run_measure(30, 16'd100, 1'b1, dly, wid, hold);
      exp_meas++;
      checks++;
      if (dly !== RESP + 2 || wid !== 292 || int'(meas_count) !== exp_meas) begin
         failures++;
         $display("FAIL post_reset_echo: delay=%0d width=%0d count=%0d required %0d/292/%0d",
                  dly, wid, meas_count, RESP + 2, exp_meas);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_short_trig;
      test_trig_min;
      test_widths;
      test_back_to_back;
      test_reset_mid_echo;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
